// File: rtl/aes_inv_cipher_iter_if.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter_if
// Bundles the ciphertext input stream, the round-key store read port and the
// plaintext output stream of aes_inv_cipher_iter.
//   in_valid  / in_ready  / in_data   : ciphertext stream (valid/ready)
//   rk_addr   / rk_data               : round-key store read, combinational
//   out_valid / out_ready / out_data  : plaintext stream (valid/ready)
// Byte i of every 128-bit word sits at bits [8i+7:8i], FIPS column-major order.
// Modports:
//   slave  : the decryptor's view
//   master : the environment's view (stream source/sink plus key store)
// -----------------------------------------------------------------------------
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_addr, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_addr, out_valid, out_data
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES-128 equivalent inverse cipher, one round per clock. The four
// output columns of a round are produced in parallel from 16 byte lookups into
// the invsbox / Td0 tables; the tables are built at elaboration time, so the
// runtime datapath is lookups and XOR only.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous, active-low reset
//   io     : aes_inv_cipher_iter_if.slave
//            in_valid/in_ready/in_data    ciphertext in (in_ready high only when idle)
//            rk_addr/rk_data              round-key store read (10 when idle)
//            out_valid/out_ready/out_data plaintext out, held until accepted
// Build option:
//   AES_INV_KEYMIX_EN defined   : the key store holds plain FIPS round keys;
//                                 InvMixColumns is applied here for rounds 9..1.
//   AES_INV_KEYMIX_EN undefined : the key store must already hold
//                                 InvMixColumns-transformed keys for indices 1..9.
// Output appears on the 10th rising edge after the input handshake.
// -----------------------------------------------------------------------------
module aes_inv_cipher_iter (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_cipher_iter_if.slave io
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } fsm_t;

    // Elaboration-time table construction ------------------------------------

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa  = a;
        bb  = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return acc;
    endfunction

    // Walks p through the powers of 3 while q tracks its inverse (powers of
    // 3^-1); the forward S-box entry at p is affine(q), so the inverse table
    // entry at that value is p.
    function automatic logic [2047:0] build_inv_sbox();
        logic [2047:0] tbl;
        logic [7:0]    p;
        logic [7:0]    q;
        logic [7:0]    x;
        tbl = '0;
        p   = 8'h01;
        q   = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            x = x ^ 8'h63;
            tbl[{x, 3'b000} +: 8] = p;
        end
        tbl[{8'h63, 3'b000} +: 8] = 8'h00;
        return tbl;
    endfunction

    // Td0 word, row 0 in the most significant byte: column 0 of InvMixColumns
    // times invsbox[x].
    function automatic logic [8191:0] build_td0(input logic [2047:0] isb);
        logic [8191:0] tbl;
        logic [7:0]    s;
        tbl = '0;
        for (int i = 0; i < 256; i++) begin
            s = isb[8*i +: 8];
            tbl[32*i +: 32] = {gf_mul(s, 8'h0e), gf_mul(s, 8'h09),
                               gf_mul(s, 8'h0d), gf_mul(s, 8'h0b)};
        end
        return tbl;
    endfunction

    localparam logic [2047:0] INV_SBOX = build_inv_sbox();
    localparam logic [8191:0] TD0      = build_td0(INV_SBOX);

    // Runtime lookups and word helpers ---------------------------------------

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] td0(input logic [7:0] x);
        return TD0[{x, 5'b00000} +: 32];
    endfunction

    function automatic logic [31:0] ror8(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic logic [31:0] ror16(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

    function automatic logic [31:0] ror24(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte s(r, c-r): the source of row r after the inverse row shift.
    function automatic logic [7:0] shifted_byte(input logic [127:0] s, input int r, input int c);
        return s[8*(4*((c - r) & 3) + r) +: 8];
    endfunction

`ifdef AES_INV_KEYMIX_EN
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
        logic [127:0] res;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2;
        logic [7:0]   x4;
        logic [7:0]   x8;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = k[8*(4*c + r) +: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            for (int r = 0; r < 4; r++) begin
                res[8*(4*c + r) +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
            end
        end
        return res;
    endfunction
`endif

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [127:0] state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [127:0] out_data_q;
    logic [3:0]   rk_addr_q;

    logic [127:0] dk;
    logic [127:0] round_full;
    logic [127:0] round_final;
    logic [31:0]  col_word;

`ifdef AES_INV_KEYMIX_EN
    assign dk = inv_mix_columns(io.rk_data);
`else
    assign dk = io.rk_data;
`endif

    // Round datapath: full and final round computed side by side; the FSM
    // picks which one is stored.
    always_comb begin
        round_full  = '0;
        round_final = '0;
        col_word    = '0;
        for (int c = 0; c < 4; c++) begin
            col_word = td0(shifted_byte(state_q, 0, c))
                     ^ ror8(td0(shifted_byte(state_q, 1, c)))
                     ^ ror16(td0(shifted_byte(state_q, 2, c)))
                     ^ ror24(td0(shifted_byte(state_q, 3, c)));
            for (int r = 0; r < 4; r++) begin
                round_full[8*(4*c + r) +: 8]  = col_word[31 - 8*r -: 8] ^ dk[8*(4*c + r) +: 8];
                round_final[8*(4*c + r) +: 8] = inv_sbox(shifted_byte(state_q, r, c))
                                              ^ io.rk_data[8*(4*c + r) +: 8];
            end
        end
    end

    // Control and state registers --------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= ST_IDLE;
            rnd         <= 4'd0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rk_addr_q   <= 4'd10;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (io.in_valid && in_ready_q) begin
                        state_q    <= io.in_data ^ io.rk_data;
                        rnd        <= 4'd9;
                        rk_addr_q  <= 4'd9;
                        in_ready_q <= 1'b0;
                        fsm        <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (rnd != 4'd0) begin
                        state_q   <= round_full;
                        rnd       <= rnd - 4'd1;
                        rk_addr_q <= rnd - 4'd1;
                    end else begin
                        out_data_q  <= round_final;
                        out_valid_q <= 1'b1;
                        rk_addr_q   <= 4'd10;
                        fsm         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm         <= ST_IDLE;
                    end
                end
                default: begin
                    fsm         <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    rk_addr_q   <= 4'd10;
                end
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.rk_addr   = rk_addr_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Bench for aes_inv_cipher_iter. The reference is a textbook AES-128 inverse
// cipher (key expansion, InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
// on byte arrays, with the S-box derived from GF(2^8) inverses at start-up.
// The key store content follows the build: plain keys with AES_INV_KEYMIX_EN,
// InvMixColumns-transformed keys 1..9 without it.
// -----------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

    logic clk = 1'b0;
    logic rst_n;

    aes_inv_cipher_iter_if bus ();

    aes_inv_cipher_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk_ref   [11];
    logic [127:0] keystore [11];

    assign bus.rk_data = (bus.rk_addr <= 4'd10) ? keystore[bus.rk_addr] : '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model --------------------------------------------------------

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return gmul_ret(p);
    endfunction

    function automatic logic [7:0] gmul_ret(input logic [7:0] v);
        return v;
    endfunction

    function automatic void build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
    endfunction

    // FIPS hex literal (byte 0 leftmost) to bus packing (byte 0 in bits 7:0).
    function automatic logic [127:0] fips(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15 - i) +: 8];
        return o;
    endfunction

    function automatic void expand_key(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 4; r++) w[i][r] = key[8*(4*i + r) +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int r = 0; r < 4; r++) t[r] = w[i-1][r];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sbox[t[1]] ^ rc;
                t[1] = sbox[t[2]];
                t[2] = sbox[t[3]];
                t[3] = sbox[tmp];
                rc   = gmul(rc, 8'h02);
            end
            for (int r = 0; r < 4; r++) w[i][r] = w[i-4][r] ^ t[r];
        end
        for (int j = 0; j < 11; j++)
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) rk_ref[j][8*(4*c + r) +: 8] = w[4*j + c][r];
    endfunction

    function automatic logic [127:0] imc128(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = v[8*(4*c + r) +: 8];
            for (int r = 0; r < 4; r++)
                o[8*(4*c + r) +: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                    ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        logic [127:0] n;
        s = ct ^ rk_ref[10];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    n[8*(4*c + r) +: 8] = inv_sbox[s[8*(4*((c - r + 4) % 4) + r) +: 8]];
            n = n ^ rk_ref[rd];
            s = (rd > 0) ? imc128(n) : n;
        end
        return s;
    endfunction

    function automatic void program_keys(input logic [127:0] key);
        expand_key(key);
        for (int j = 0; j < 11; j++) keystore[j] = rk_ref[j];
`ifndef AES_INV_KEYMIX_EN
        for (int j = 1; j < 10; j++) keystore[j] = imc128(rk_ref[j]);
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stimulus ---------------------------------------------------------------

    // Called just after a falling edge. Offers ct, measures the latency from
    // the input handshake edge, optionally withholds out_ready for `stall`
    // cycles, then completes the output handshake.
    task automatic decrypt_one(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                               input bit hold_valid, input int stall);
        int           waited;
        int           lat;
        logic [127:0] held;
        bus.in_data  = ct;
        bus.in_valid = 1'b1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, 128'(bus.in_ready), 128'd1);
        if (bus.in_ready !== 1'b1) return;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) bus.in_valid = 1'b0;
        bus.in_data = rand128();
        check({tag, "_busy"}, 128'(bus.in_ready), 128'd0);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_data"}, bus.out_data, exp);
        if (lat == 0) return;
        held = bus.out_data;
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, "_hold_data"}, bus.out_data, held);
                check({tag, "_hold_valid"}, 128'(bus.out_valid), 128'd1);
                check({tag, "_hold_inready"}, 128'(bus.in_ready), 128'd0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_out_cleared"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_ready_again"}, 128'(bus.in_ready), 128'd1);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [127:0] ct;
        logic [127:0] exp;
        int           vcount;

        build_tables();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        program_keys(fips(C1_KEY));

        #12;
        check("reset_in_ready", 128'(bus.in_ready), 128'd1);
        check("reset_out_valid", 128'(bus.out_valid), 128'd0);
        check("reset_out_data", bus.out_data, 128'd0);
        check("reset_rk_addr", 128'(bus.rk_addr), 128'd10);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1
        bus.out_ready = 1'b1;
        decrypt_one("c1", fips(C1_CT), fips(C1_PT), 1'b0, 0);

        // All-zero key and plaintext
        program_keys('0);
        decrypt_one("zero_key", fips(Z_CT), '0, 1'b0, 0);

        // Backpressure with in_valid held high during the stall
        program_keys(fips(C1_KEY));
        decrypt_one("bp_first", fips(C1_CT), fips(C1_PT), 1'b1, 5);
        ct  = rand128();
        exp = ref_decrypt(ct);
        decrypt_one("bp_second", ct, exp, 1'b0, 0);

        // Asynchronous reset during the 5th round cycle
        bus.in_data  = fips(C1_CT);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        check("midrst_out_data", bus.out_data, 128'd0);
        check("midrst_rk_addr", 128'(bus.rk_addr), 128'd10);
        @(negedge clk);
        rst_n  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) vcount++;
        end
        check("midrst_block_lost", 128'(vcount), 128'd0);
        decrypt_one("after_reset", fips(C1_CT), fips(C1_PT), 1'b0, 0);

        // Random keys and ciphertexts, random output stalls and idle gaps
        for (int b = 0; b < 4; b++) begin
            program_keys(rand128());
            ct  = rand128();
            exp = ref_decrypt(ct);
            decrypt_one($sformatf("rand%0d", b), ct, exp, 1'b0, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Back-to-back: in_valid and out_ready held high over three blocks
        program_keys(rand128());
        bus.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            ct  = rand128();
            exp = ref_decrypt(ct);
            decrypt_one($sformatf("b2b%0d", b), ct, exp, (b < 2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
